// File: rtl/pulse_handshake_tx_if.sv
// Source-side signals of the 2-phase req/ack pulse-crossing handshake.
// The master modport is the transmitter side. The slave modport is the event source and far-domain side.
interface pulse_handshake_tx_if #(
    parameter int unsigned CNT_W = 4
);
    logic             din;
    logic             ack_toggle;
    logic             req_toggle;
    logic             busy;
    logic [CNT_W-1:0] pending;
    logic             overflow;

    modport master (
        input  din,
        input  ack_toggle,
        output req_toggle,
        output busy,
        output pending,
        output overflow
    );

    modport slave (
        output din,
        output ack_toggle,
        input  req_toggle,
        input  busy,
        input  pending,
        input  overflow
    );
endinterface

// File: rtl/pulse_handshake_tx.sv
// Transmitter for a 2-phase req/ack pulse crossing. It queues din events and sends each one
// as a single req_toggle flip. It waits for the synchronized ack to match before it sends the next event.
module pulse_handshake_tx #(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 resetn,
    pulse_handshake_tx_if.master hs
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic [CNT_W-1:0]       pend_q, pend_d;
    logic                   ovf_q, ovf_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_sync;
    logic                   inc, dec;

    // The ack level arrives from the far clock domain, so it passes through a flop chain first
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], hs.ack_toggle};
        end
    end

    assign ack_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    // A launch takes the oldest queued event first; din is counted whenever it is not launched directly
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        pend_d  = pend_q;
        ovf_d   = 1'b0;
        inc     = 1'b0;
        dec     = 1'b0;

        case (state_q)
            IDLE: begin
                if (hs.din || (pend_q != '0)) begin
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                    if (pend_q != '0) begin
                        dec = 1'b1;
                        inc = hs.din;
                    end
                end
            end
            WAIT_ACK: begin
                inc = hs.din;
                if (ack_sync == req_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // When the counter is full, an extra event is dropped and flagged. The counter never wraps.
        if (inc && !dec) begin
            if (pend_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - CNT_W'(1);
        end
    end

    assign hs.req_toggle = req_q;
    assign hs.pending    = pend_q;
    assign hs.overflow   = ovf_q;
    assign hs.busy       = (state_q == WAIT_ACK) || (pend_q != '0);

endmodule
